// File: rtl/pipe_pc_sched.sv
// Program-counter and IF/ID front-end sequencer for the five-stage pipeline.
// Arbitrates stalls, multicycle EXE ops, branches, exception entry and eret.
module pipe_pc_sched #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ld_hazard,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_len,
    input  logic             br_taken,
    input  logic             exc_req,
    input  logic             eret,
    output logic             wpc,
    output logic             wpcir,
    output logic [1:0]       npc_sel,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             wepc,
    output logic             busy,
    output logic [1:0]       state
);

    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] MC  = 2'b01;
    localparam logic [1:0] EXC = 2'b10;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_VEC = 2'b10;
    localparam logic [1:0] NPC_EPC = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             exc_pend_r;
    logic             exc_pend_nxt_s;
    logic             mc_go_s;

    // mc_len of 0 or 1 completes in a single EXE cycle and never enters MC
    assign mc_go_s = mc_start & (mc_len >= CNT_TWO);
    assign state   = state_r;

    // State, counter and pending-exception registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r    <= RUN;
            cnt_r      <= {CNT_W{1'b0}};
            exc_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            exc_pend_r <= exc_pend_nxt_s;
        end
    end

    // Next-state, counter and pending-exception logic
    always_comb begin
        state_nxt_s    = RUN;
        cnt_nxt_s      = cnt_r;
        exc_pend_nxt_s = exc_pend_r;
        case (state_r)
            RUN: begin
                if (exc_req || exc_pend_r) begin
                    state_nxt_s = EXC;
                end else if (eret) begin
                    state_nxt_s = RUN;
                end else if (mc_go_s) begin
                    state_nxt_s = MC;
                    cnt_nxt_s   = mc_len - CNT_ONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MC: begin
                // A zero count can only arise from corruption; leave MC rather than wrap
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = MC;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
                if (exc_req) begin
                    exc_pend_nxt_s = 1'b1;
                end else begin
                    exc_pend_nxt_s = exc_pend_r;
                end
            end
            EXC: begin
                state_nxt_s    = RUN;
                exc_pend_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode; RUN-idle unless a state or RUN priority item overrides
    always_comb begin
        wpc         = 1'b1;
        wpcir       = 1'b1;
        npc_sel     = NPC_SEQ;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        wepc        = 1'b0;
        busy        = 1'b0;
        if (!clrn) begin
            wpc   = 1'b0;
            wpcir = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (exc_req || exc_pend_r) begin
                        wepc        = 1'b1;
                        wpc         = 1'b0;
                        wpcir       = 1'b0;
                        bubble_idex = 1'b1;
                    end else if (eret) begin
                        npc_sel    = NPC_EPC;
                        flush_ifid = 1'b1;
                    end else if (mc_go_s) begin
                        npc_sel = NPC_SEQ;
                    end else if (ld_hazard) begin
                        wpc         = 1'b0;
                        wpcir       = 1'b0;
                        bubble_idex = 1'b1;
                    end else if (br_taken) begin
                        npc_sel    = NPC_BR;
                        flush_ifid = 1'b1;
                    end else begin
                        npc_sel = NPC_SEQ;
                    end
                end
                MC: begin
                    wpc   = 1'b0;
                    wpcir = 1'b0;
                    busy  = 1'b1;
                end
                EXC: begin
                    npc_sel     = NPC_VEC;
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
                default: begin
                    npc_sel = NPC_SEQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_pc_sched.sv
// Self-checking bench for pipe_pc_sched: directed scenarios plus random traffic
// compared against a cycle-counting reference model.
module tb_pipe_pc_sched;

    logic       clk;
    logic       clrn;
    logic       ld_hazard;
    logic       mc_start;
    logic [3:0] mc_len;
    logic       br_taken;
    logic       exc_req;
    logic       eret;
    logic       wpc;
    logic       wpcir;
    logic [1:0] npc_sel;
    logic       flush_ifid;
    logic       bubble_idex;
    logic       wepc;
    logic       busy;
    logic [1:0] state;

    int cmps  = 0;
    int fails = 0;

    // Reference model: remaining MC cycles, exception-entry cycle flag, pending flag
    int m_mc_left;
    bit m_exc;
    bit m_pend;

    logic [9:0] obs;
    logic [9:0] exp_v;

    localparam logic [9:0] RUN_IDLE = 10'b1100000000;

    pipe_pc_sched #(.CNT_W(4)) dut (
        .clk(clk), .clrn(clrn), .ld_hazard(ld_hazard), .mc_start(mc_start),
        .mc_len(mc_len), .br_taken(br_taken), .exc_req(exc_req), .eret(eret),
        .wpc(wpc), .wpcir(wpcir), .npc_sel(npc_sel), .flush_ifid(flush_ifid),
        .bubble_idex(bubble_idex), .wepc(wepc), .busy(busy), .state(state)
    );

    assign obs = {wpc, wpcir, npc_sel, flush_ifid, bubble_idex, wepc, busy, state};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] pack(bit w, bit wi, logic [1:0] ns, bit fl, bit bu,
                                        bit we, bit by, logic [1:0] st);
        return {w, wi, ns, fl, bu, we, by, st};
    endfunction

    function automatic logic [9:0] model_out();
        if (!clrn) return 10'b0;
        if (m_exc) return pack(1, 1, 2'b10, 1, 1, 0, 0, 2'b10);
        if (m_mc_left > 0) return pack(0, 0, 2'b00, 0, 0, 0, 1, 2'b01);
        if (exc_req || m_pend) return pack(0, 0, 2'b00, 0, 1, 1, 0, 2'b00);
        if (eret) return pack(1, 1, 2'b11, 1, 0, 0, 0, 2'b00);
        if (mc_start && int'(mc_len) >= 2) return RUN_IDLE;
        if (ld_hazard) return pack(0, 0, 2'b00, 0, 1, 0, 0, 2'b00);
        if (br_taken) return pack(1, 1, 2'b01, 1, 0, 0, 0, 2'b00);
        return RUN_IDLE;
    endfunction

    task automatic model_reset();
        m_mc_left = 0;
        m_exc     = 1'b0;
        m_pend    = 1'b0;
    endtask

    task automatic model_step();
        if (!clrn) begin
            model_reset();
        end else if (m_exc) begin
            m_exc  = 1'b0;
            m_pend = 1'b0;
        end else if (m_mc_left > 0) begin
            if (exc_req) m_pend = 1'b1;
            m_mc_left--;
        end else if (exc_req || m_pend) begin
            m_exc = 1'b1;
        end else if (!eret && mc_start && int'(mc_len) >= 2) begin
            m_mc_left = int'(mc_len) - 1;
        end
    endtask

    task automatic drive(bit ld, bit ms, logic [3:0] ln, bit br, bit ex, bit er);
        ld_hazard = ld; mc_start = ms; mc_len = ln; br_taken = br; exc_req = ex; eret = er;
    endtask

    // Advance one clock: model samples the held inputs at the edge
    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        drive(0, 0, 4'd0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #3;
            cmps++;
            if (obs !== 10'b0) begin
                fails++;
                $display("FAIL reset_hold c%0d obs=%b exp=%b", i, obs, 10'b0);
            end
            adv();
        end
        clrn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            cmps++;
            if (obs !== RUN_IDLE) begin
                fails++;
                $display("FAIL reset_idle c%0d obs=%b exp=%b", i, obs, RUN_IDLE);
            end
            adv();
        end
    endtask

    task automatic test_hazard_branch();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(1, 0, 4'd0, 0, 0, 0);
                1: drive(0, 0, 4'd0, 1, 0, 0);
                default: drive(1, 0, 4'd0, 1, 0, 0);
            endcase
            #3;
            exp_v = model_out();
            cmps++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL hazard_branch c%0d obs=%b exp=%b", i, obs, exp_v);
            end
            adv();
        end
        drive(0, 0, 4'd0, 0, 0, 0);
    endtask

    task automatic test_multicycle(logic [3:0] len);
        int n_mc;
        n_mc = 0;
        drive(0, 1, len, 0, 0, 0);
        for (int i = 0; i < int'(len) + 2; i++) begin
            #3;
            exp_v = model_out();
            cmps++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL multicycle len%0d c%0d obs=%b exp=%b", len, i, obs, exp_v);
            end
            if (state == 2'b01) n_mc++;
            adv();
            drive(0, 0, 4'd0, 0, 0, 0);
        end
        cmps++;
        if (n_mc != ((int'(len) >= 2) ? int'(len) - 1 : 0)) begin
            fails++;
            $display("FAIL mc_length len%0d obs=%0d exp=%0d", len, n_mc,
                     (int'(len) >= 2) ? int'(len) - 1 : 0);
        end
    endtask

    task automatic test_exc_in_mc();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(0, 1, 4'd4, 0, 0, 0);
                2: drive(0, 0, 4'd0, 0, 1, 0);
                default: drive(0, 0, 4'd0, 0, 0, 0);
            endcase
            #3;
            exp_v = model_out();
            cmps++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL exc_in_mc c%0d obs=%b exp=%b", i, obs, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_exc_priority();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(0, 0, 4'd0, 1, 1, 1);
                3: drive(0, 0, 4'd0, 0, 0, 1);
                default: drive(0, 0, 4'd0, 0, 0, 0);
            endcase
            #3;
            exp_v = model_out();
            cmps++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL exc_priority c%0d obs=%b exp=%b", i, obs, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_mc();
        drive(0, 1, 4'd6, 0, 0, 0);
        adv();
        drive(0, 0, 4'd0, 0, 1, 0);
        adv();
        drive(0, 0, 4'd0, 0, 0, 0);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        cmps++;
        if (obs !== 10'b0) begin
            fails++;
            $display("FAIL reset_mid_mc obs=%b exp=%b", obs, 10'b0);
        end
        adv();
        clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            cmps++;
            if (obs !== RUN_IDLE) begin
                fails++;
                $display("FAIL post_reset c%0d obs=%b exp=%b", i, obs, RUN_IDLE);
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            #3;
            exp_v = model_out();
            cmps++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL random c%0d obs=%b exp=%b", i, obs, exp_v);
            end
            adv();
        end
        drive(0, 0, 4'd0, 0, 0, 0);
    endtask

    initial begin
        clrn = 1'b0;
        drive(0, 0, 4'd0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_hazard_branch();
        test_multicycle(4'd5);
        test_multicycle(4'd1);
        test_multicycle(4'd15);
        test_exc_in_mc();
        test_exc_priority();
        test_reset_mid_mc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule

// File: doc/pipe_pc_sched.md
Name: pipe_pc_sched

Overview:
- Per-cycle sequencer for the five-stage pipeline's program counter and IF/ID front end.
- Decides when the PC register loads and which next-PC source the npc mux selects.
- Decides when IF/ID holds or is flushed, and when a bubble goes into ID/EX.
- Arbitrates among load-use stalls, multicycle EXE ops, taken branches/jumps, exception entry and eret.

Parameters:
CNT_W, 4, width of multicycle length input and internal down-counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clrn  in  1  reset; asynchronous, active-low.
- ld_hazard  in  1  load-use hazard detected in ID.
- mc_start  in  1  ID holds a multicycle op (mul/div) issuing to EXE this cycle.
- mc_len  in  CNT_W  total EXE cycles of that op; sampled only with mc_start.
- br_taken  in  1  branch/jump resolved taken in ID.
- exc_req  in  1  masked exception/interrupt request.
- eret  in  1  eret decoded in ID.
- wpc  out  1  PC write enable.
- wpcir  out  1  IF/ID write enable.
- npc_sel  out  2  next-PC select: 00 pc+4, 01 branch/jump target, 10 exception vector, 11 EPC.
- flush_ifid  out  1  cancel instruction in IF/ID (load nop).
- bubble_idex  out  1  insert nop into ID/EX.
- wepc  out  1  capture EPC/cause this cycle.
- busy  out  1  multicycle op occupying EXE (EXE holds).
- state  out  2  current state, debug.

Behaviour:
- States: RUN=00, MC=01, EXC=10; 11 unused, recovers to RUN next cycle with all outputs as RUN-idle.
- Internal regs: state, cnt[CNT_W-1:0], exc_pend.
- Reset (clrn=0, asynchronous): state=RUN, cnt=0, exc_pend=0.
- While clrn=0, outputs forced: wpc=0, wpcir=0, npc_sel=00, flush_ifid=0, bubble_idex=0, wepc=0, busy=0.
- Outputs are combinational from state plus current inputs, zero latency. Default is RUN-idle: wpc=1, wpcir=1, npc_sel=00, all others 0.
- RUN, strict priority, first match wins:
  1. exc_req or exc_pend: wepc=1, wpc=0, wpcir=0, bubble_idex=1; next EXC.
  2. eret: npc_sel=11, wpc=1, wpcir=1, flush_ifid=1; stay RUN.
  3. mc_start with mc_len>=2: RUN-idle outputs (op advances into EXE); cnt<=mc_len-1; next MC. With mc_len 0 or 1, treated as single-cycle, no state change.
  4. ld_hazard: wpc=0, wpcir=0, bubble_idex=1; stay RUN.
  5. br_taken: npc_sel=01, wpc=1, wpcir=1, flush_ifid=1 (no delay slot); stay RUN.
- Simultaneous ld_hazard and br_taken: stall wins. The branch re-resolves next cycle.
- MC: wpc=0, wpcir=0, busy=1, bubble_idex=0.
  - cnt decrements each cycle; when cnt==1 at a clock edge, next RUN.
  - MC therefore lasts exactly mc_len-1 cycles.
  - exc_req in MC sets exc_pend=1 and is not taken; eret/br_taken/ld_hazard in MC are ignored (ID is frozen and re-presents them).
- EXC, one cycle: npc_sel=10, wpc=1, wpcir=1, flush_ifid=1, bubble_idex=1; exc_pend<=0; next RUN.
  - exc_req in EXC is ignored; the requester holds it and it is taken on a later RUN cycle.
- exc_pend set and clear in the same cycle: set wins only if the request arrives in MC, so no conflict arises.
- Counter never wraps: loaded only from RUN with mc_len>=2.
- mc_len=2^CNT_W-1 is legal and gives 2^CNT_W-2 MC cycles.
- Reset mid-MC or mid-EXC: immediate return to RUN; pending exception dropped.

Test Plan:
1. Reset then idle inputs for 5 cycles → during reset wpc=0, wpcir=0, state=00. After release wpc=1, wpcir=1, npc_sel=00 every cycle.
2. ld_hazard=1 one cycle, then br_taken=1 one cycle → cycle 1: wpc=0, wpcir=0, bubble_idex=1. Cycle 2: npc_sel=01, wpc=1, flush_ifid=1.
3. mc_start=1, mc_len=5 → start cycle RUN-idle. Next 4 cycles state=01, busy=1, wpc=0. Then state=00, wpc=1. Repeat with mc_len=1 → no MC.
4. mc_start, mc_len=4; exc_req pulsed in 2nd MC cycle → 3 MC cycles, then RUN cycle with wepc=1, wpc=0. Then EXC cycle with npc_sel=10, flush_ifid=1, bubble_idex=1. Then RUN-idle.
5. exc_req=1 with eret=1 and br_taken=1 same cycle in RUN → exception path (wepc=1), eret ignored. Next cycle npc_sel=10. Eret alone later → npc_sel=11, flush_ifid=1.
6. clrn pulled low in 2nd MC cycle of mc_len=6 (with exc_pend set) → outputs forced low immediately. After release: state=00, busy=0, no exception entry.
